ram_dumper: RTL and testbench

RAM_DUMPER -- requirements
Module: ram_dumper

---
 rtl/ram_dumper.sv | 189 ++++++++++++++++++
 tb/tb_ram_dumper.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - streams CPU instruction RAM words 0..LAST_ADDR to a ready/valid consumer
//
// Purpose:
//   While a dump is in progress the CPU is frozen (PC_Hold) and each RAM word
//   is read, captured and then offered on Dump_Data until the consumer accepts it.
//   Every word costs three cycles: READ (strobe), CAPT (RAM data returns), SEND.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              dump request, only honoured in IDLE
//   RAM_Read_Address   RAM read address (always the word counter)
//   RAM_Read_Enable    read strobe, RAM answers on RAM_Read_Data one cycle later
//   RAM_Read_Data      9-bit RAM word
//   Dump_Data          word offered to the consumer
//   Dump_Valid         Dump_Data is valid
//   Dump_Ready         consumer accepts Dump_Data this cycle
//   Dump_Last          marks the final word of the dump
//   PC_Hold            high whenever the dumper is not idle
//   done               one-cycle pulse after the final transfer
//
// Configuration:
//   DUMP_CHECKSUM_EN   when defined, an XOR checksum of all RAM words is sent
//                      as an extra final word.

module ram_dumper #(
  parameter logic [2:0] LAST_ADDR = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] RAM_Read_Address,
  output logic       RAM_Read_Enable,
  input  logic [8:0] RAM_Read_Data,
  output logic [8:0] Dump_Data,
  output logic       Dump_Valid,
  input  logic       Dump_Ready,
  output logic       Dump_Last,
  output logic       PC_Hold,
  output logic       done
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    CKSUM = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd5
  } state_t;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [2:0] addr_q;
  logic [8:0] data_q;
  logic       at_last;

`ifdef DUMP_CHECKSUM_EN
  logic [8:0] acc_q;
`endif

  // The counter stops at LAST_ADDR instead of wrapping, so this is also the
  // "final RAM word" flag.
  assign at_last          = (addr_q == LAST_ADDR);
  assign RAM_Read_Address = addr_q;
  assign Dump_Data        = data_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d         = state_q;
    RAM_Read_Enable = 1'b0;
    Dump_Valid      = 1'b0;
    Dump_Last       = 1'b0;
    done            = 1'b0;
    PC_Hold         = 1'b1;
    case (state_q)
      IDLE: begin
        PC_Hold = 1'b0;
        if (start) begin
          state_d = READ;
        end
      end
      READ: begin
        RAM_Read_Enable = 1'b1;
        state_d         = CAPT;
      end
      CAPT: begin
        state_d = SEND;
      end
      SEND: begin
        Dump_Valid = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        // The checksum word, not the last RAM word, closes the dump.
        Dump_Last  = 1'b0;
`else
        Dump_Last  = at_last;
`endif
        if (Dump_Ready) begin
          if (!at_last) begin
            state_d = READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d = CKSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CKSUM: begin
        Dump_Valid = 1'b1;
        Dump_Last  = 1'b1;
        if (Dump_Ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: word counter, output word register and optional checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 3'd0;
      data_q <= 9'd0;
`ifdef DUMP_CHECKSUM_EN
      acc_q  <= 9'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= 3'd0;
`ifdef DUMP_CHECKSUM_EN
            acc_q  <= 9'd0;
`endif
          end
        end
        CAPT: begin
          data_q <= RAM_Read_Data;
        end
        SEND: begin
          if (Dump_Ready) begin
            if (!at_last) begin
              addr_q <= addr_q + 3'd1;
            end
`ifdef DUMP_CHECKSUM_EN
            acc_q <= acc_q ^ data_q;
            // Load the finished checksum straight into the output register so
            // CKSUM presents it with the same hold-until-accepted behaviour.
            if (at_last) begin
              data_q <= acc_q ^ data_q;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dumper.sv
// tb/tb_ram_dumper.sv - self-checking bench for ram_dumper

module tb_ram_dumper;

`ifdef DUMP_CHECKSUM_EN
  localparam int WORDS  = 9;
  localparam int WORDS1 = 2;
  localparam bit CK     = 1'b1;
`else
  localparam int WORDS  = 8;
  localparam int WORDS1 = 1;
  localparam bit CK     = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       Dump_Ready;
  logic [2:0] RAM_Read_Address;
  logic       RAM_Read_Enable;
  logic [8:0] RAM_Read_Data;
  logic [8:0] Dump_Data;
  logic       Dump_Valid;
  logic       Dump_Last;
  logic       PC_Hold;
  logic       done;

  logic       start1;
  logic       ready1;
  logic [2:0] addr1;
  logic       re1;
  logic [8:0] rd1;
  logic [8:0] data1;
  logic       valid1;
  logic       last1;
  logic       hold1;
  logic       done1;

  logic [8:0] mem [8];

  ram_dumper u_dut (
    .clk(clk), .reset(reset), .start(start),
    .RAM_Read_Address(RAM_Read_Address), .RAM_Read_Enable(RAM_Read_Enable),
    .RAM_Read_Data(RAM_Read_Data), .Dump_Data(Dump_Data), .Dump_Valid(Dump_Valid),
    .Dump_Ready(Dump_Ready), .Dump_Last(Dump_Last), .PC_Hold(PC_Hold), .done(done)
  );

  ram_dumper #(.LAST_ADDR(3'd0)) u_one (
    .clk(clk), .reset(reset), .start(start1),
    .RAM_Read_Address(addr1), .RAM_Read_Enable(re1),
    .RAM_Read_Data(rd1), .Dump_Data(data1), .Dump_Valid(valid1),
    .Dump_Ready(ready1), .Dump_Last(last1), .PC_Hold(hold1), .done(done1)
  );

  // Synchronous-read RAM models: data one cycle after the strobe
  always @(posedge clk) begin
    if (RAM_Read_Enable) RAM_Read_Data <= mem[RAM_Read_Address];
    if (re1) rd1 <= mem[addr1];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [8:0] w0;
    logic [8:0] w1;
    logic [8:0] rest_base;
    logic [8:0] rest_step;
    int         stall_word;
    int         stall_len;
    int         extra_start_word;
    int         exp_words;
  } vec_t;

  typedef struct {
    logic [8:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard monitor
  int         cyc = 0;
  int         xfer_count = 0;
  int         done_count = 0;
  int         last_xfer_cyc = -10;
  int         prev_xfer_cyc = 0;
  bit         have_prev = 1'b0;
  bit         gap_check = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_data = 9'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (Dump_Valid) check("read_en_while_valid", RAM_Read_Enable, 0);
      if (!Dump_Valid) check("last_without_valid", Dump_Last, 0);
      if (prev_stall && Dump_Valid) check("data_stable", Dump_Data, prev_data);
      if (Dump_Valid && Dump_Ready) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word_data", Dump_Data, e.data);
          check("word_last", Dump_Last, e.last);
          if (gap_check && have_prev) check("word_gap", cyc - prev_xfer_cyc, 3);
          have_prev     = !e.last;
          prev_xfer_cyc = cyc;
          if (e.last) last_xfer_cyc = cyc;
        end
      end
      if (done) begin
        done_count++;
        check("done_after_last", cyc - last_xfer_cyc, 1);
        check("valid_in_done", Dump_Valid, 0);
      end
      prev_stall = Dump_Valid && !Dump_Ready;
      prev_data  = Dump_Data;
    end else begin
      prev_stall = 1'b0;
      have_prev  = 1'b0;
    end
  end

  task automatic load_and_push(input vec_t v);
    logic [8:0] val;
    logic [8:0] acc;
    mem[0] = v.w0;
    mem[1] = v.w1;
    val = v.rest_base;
    for (int i = 2; i < 8; i++) begin
      mem[i] = val;
      val = val + v.rest_step;
    end
    acc = 9'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ mem[i];
      exp_q.push_back('{data: mem[i], last: (!CK && i == 7)});
    end
    if (CK) exp_q.push_back('{data: acc, last: 1'b1});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, Dump_Data, 0);
    check({tag, "_valid"}, Dump_Valid, 0);
    check({tag, "_last"}, Dump_Last, 0);
    check({tag, "_read_en"}, RAM_Read_Enable, 0);
    check({tag, "_pc_hold"}, PC_Hold, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, RAM_Read_Address, 0);
  endtask

  task automatic run_dump(input vec_t v);
    int base_x;
    int base_d;
    int stall_left;
    int fv;
    bit extra_done;
    bit hold_bad;
    load_and_push(v);
    gap_check  = (v.stall_len == 0);
    base_x     = xfer_count;
    base_d     = done_count;
    stall_left = v.stall_len;
    fv         = -1;
    extra_done = 1'b0;
    hold_bad   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    Dump_Ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // k counts cycles after the edge that sampled start
    for (int k = 0; k < 200 && done_count == base_d; k++) begin
      if (Dump_Valid && fv < 0) fv = k;
      if (!PC_Hold) hold_bad = 1'b1;
      start = (!extra_done && (xfer_count - base_x) == v.extra_start_word);
      if (start) extra_done = 1'b1;
      if (Dump_Valid && (xfer_count - base_x) == v.stall_word && stall_left > 0) begin
        Dump_Ready = 1'b0;
        stall_left--;
      end else begin
        Dump_Ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    Dump_Ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("first_valid_latency", fv, 2);
    check("pc_hold_during_dump", hold_bad, 0);
    check("stall_applied", stall_left, 0);
    check("word_count", xfer_count - base_x, v.exp_words);
    check("done_pulses", done_count - base_d, 1);
    check("queue_drained", exp_q.size(), 0);
    check("pc_hold_idle", PC_Hold, 0);
    check("addr_holds_last", RAM_Read_Address, 7);
    exp_q.delete();
  endtask

  vec_t vecs[4];

  initial begin
    int base_x;
    int base_d;
    int n1;
    bit seen_done1;
    bit hold1_bad;
    logic [8:0] d1 [2];
    logic       l1 [2];

    vecs[0] = '{9'o101, 9'o102, 9'o103, 9'd1,     -1, 0, -1, WORDS};
    vecs[1] = '{9'o101, 9'o102, 9'o103, 9'd1,      1, 5, -1, WORDS};
    vecs[2] = '{9'h155, 9'h0AA, 9'h1E1, 9'h033,   -1, 0,  3, WORDS};
    vecs[3] = '{9'h1FF, 9'h0F0, 9'h000, 9'h000,   -1, 0, -1, WORDS};

    reset = 1'b1; start = 1'b0; Dump_Ready = 1'b1;
    start1 = 1'b0; ready1 = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_u1_hold", hold1, 0);
    reset = 1'b0;

    for (int t = 0; t < 4; t++) run_dump(vecs[t]);

    // Reset while the fourth word is being offered
    load_and_push(vecs[0]);
    gap_check = 1'b0;
    base_x = xfer_count;
    base_d = done_count;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (Dump_Valid && (xfer_count - base_x) == 3) break;
      @(posedge clk); #1;
    end
    check("reached_word4", Dump_Valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("midreset");
    check("midreset_words_left", exp_q.size(), WORDS - 3);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("midreset_no_done", done_count - base_d, 0);
    check("midreset_stays_idle", PC_Hold, 0);
    run_dump(vecs[0]);

    // Single-word dump on the LAST_ADDR=0 instance
    mem[0] = 9'h0A5;
    n1 = 0; seen_done1 = 1'b0; hold1_bad = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 30 && !seen_done1; k++) begin
      if (!hold1) hold1_bad = 1'b1;
      if (done1) seen_done1 = 1'b1;
      if (valid1) begin
        if (n1 < 2) begin
          d1[n1] = data1;
          l1[n1] = last1;
        end
        n1++;
      end
      @(posedge clk); #1;
    end
    check("u1_done_seen", seen_done1, 1);
    check("u1_pc_hold_during", hold1_bad, 0);
    check("u1_pc_hold_after", hold1, 0);
    check("u1_word_count", n1, WORDS1);
    if (n1 >= 1) begin
      check("u1_word0_data", d1[0], 9'h0A5);
      check("u1_word0_last", l1[0], !CK);
    end
    if (n1 == 2) begin
      check("u1_cksum_data", d1[1], 9'h0A5);
      check("u1_cksum_last", l1[1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
